histogram_cdf_scan: RTL and testbench

Post-frame reader for the 256-bin grey-level histogram RAM. After the histogram writer has finished a frame, this block sweeps every bin in address order. It streams each bin's count together with the running cumulative sum (CDF) to the equalisation stage over a valid/ready handshake. Optionally it zeroes each bin as it is consumed, so the RAM is clean for the next frame.

---
 rtl/histogram_cdf_scan.sv | 134 +++++++++++++
 tb/tb_histogram_cdf_scan.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/histogram_cdf_scan.sv
// rtl/histogram_cdf_scan.sv - post-frame histogram sweep streaming bin count and saturating CDF.
// Optional clear-on-read of each consumed bin is enabled by defining HISTO_CLEAR_ON_READ_EN.
module histogram_cdf_scan #(
    parameter int COUNT_W = 20,
    parameter int ADDR_W  = 8
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iStart,
    output logic [ADDR_W-1:0]  oReadAddr,
    input  logic [COUNT_W-1:0] iDataIn,
    output logic [ADDR_W-1:0]  oWriteAddr,
    output logic               oWriteEnable,
    output logic [COUNT_W-1:0] oDataOut,
    output logic               oValid,
    input  logic               iReady,
    output logic [ADDR_W-1:0]  oBin,
    output logic [COUNT_W-1:0] oCount,
    output logic [COUNT_W-1:0] oCdf,
    output logic               oLast,
    output logic               oBusy,
    output logic               oDone
);

    localparam logic [ADDR_W-1:0] LAST_BIN = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  ptr;
    logic [COUNT_W-1:0] acc;
    logic               fetched_all;
    logic               active;
    logic               load;
    logic               accept;
    logic               last_accept;
    logic [COUNT_W:0]   sum;
    logic [COUNT_W-1:0] cdf_next;

    assign active      = (state == PRIME) || (state == RUN);
    assign load        = active && !fetched_all && (!oValid || iReady);
    assign accept      = oValid && iReady;
    assign last_accept = (state == RUN) && accept && oLast;
    assign sum         = {1'b0, acc} + {1'b0, iDataIn};
    assign cdf_next    = sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];
    assign oDataOut    = '0;

    // The RAM has one cycle of read latency, so the address presented now must be
    // the bin the slot will load at the next edge: advance early on a load, hold on a stall.
    always_comb begin
        oReadAddr = ptr;
        if (state == IDLE) begin
            oReadAddr = '0;
        end else if (load && (ptr != LAST_BIN)) begin
            oReadAddr = ptr + 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            acc         <= '0;
            fetched_all <= 1'b0;
            oValid      <= 1'b0;
            oBin        <= '0;
            oCount      <= '0;
            oCdf        <= '0;
            oLast       <= 1'b0;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        state       <= PRIME;
                        ptr         <= '0;
                        acc         <= '0;
                        fetched_all <= 1'b0;
                        oBusy       <= 1'b1;
                    end
                end
                PRIME: state <= RUN;
                RUN: begin
                    if (last_accept) begin
                        state <= DONE;
                        oDone <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                oValid <= 1'b1;
                oBin   <= ptr;
                oCount <= iDataIn;
                oCdf   <= cdf_next;
                acc    <= cdf_next;
                oLast  <= (ptr == LAST_BIN);
                // The pointer parks on the final bin so nothing past it is ever fetched.
                if (ptr == LAST_BIN) begin
                    fetched_all <= 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end else if (accept) begin
                oValid <= 1'b0;
            end
        end
    end

`ifdef HISTO_CLEAR_ON_READ_EN
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oWriteEnable <= 1'b0;
            oWriteAddr   <= '0;
        end else begin
            oWriteEnable <= accept;
            if (accept) begin
                oWriteAddr <= oBin;
            end
        end
    end
`else
    assign oWriteEnable = 1'b0;
    assign oWriteAddr   = '0;
`endif

endmodule

// File: tb/tb_histogram_cdf_scan.sv
// tb/tb_histogram_cdf_scan.sv - scoreboard bench for histogram_cdf_scan with a behavioural RAM.
module tb_histogram_cdf_scan;

    localparam int CW = 20;
    localparam int AW = 8;
    localparam int NB = 256;
    localparam longint MAXC = 64'h0000_0000_000F_FFFF;
`ifdef HISTO_CLEAR_ON_READ_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef logic [AW+2*CW:0] beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_data;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic [CW-1:0] wr_data;
    logic          valid;
    logic          ready;
    logic [AW-1:0] bin;
    logic [CW-1:0] count;
    logic [CW-1:0] cdf;
    logic          last;
    logic          busy;
    logic          done;

    logic [CW-1:0] mem [NB];
    logic [CW-1:0] img [NB];
    logic          load_ram;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc, wr_cnt, wr_next, last_cyc, done_cyc;
    bit    prev_stall;
    beat_t prev_out;
    logic [CW-1:0] last_cdf;

    always #5 clk = ~clk;

    histogram_cdf_scan #(.COUNT_W(CW), .ADDR_W(AW)) dut (
        .iClk(clk), .iRst_n(rst_n), .iStart(start),
        .oReadAddr(rd_addr), .iDataIn(rd_data),
        .oWriteAddr(wr_addr), .oWriteEnable(wr_en), .oDataOut(wr_data),
        .oValid(valid), .iReady(ready), .oBin(bin), .oCount(count), .oCdf(cdf),
        .oLast(last), .oBusy(busy), .oDone(done)
    );

    // Synchronous-read RAM: data appears the cycle after the address.
    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (load_ram) begin
            for (int i = 0; i < NB; i++) mem[i] <= img[i];
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic load_img();
        load_ram = 1'b1;
        advance();
        load_ram = 1'b0;
    endtask

    task automatic push_exp();
        longint acc = 0;
        for (int i = 0; i < NB; i++) begin
            acc += longint'(img[i]);
            if (acc > MAXC) acc = MAXC;
            q.push_back({AW'(i), img[i], CW'(acc), (i == NB - 1)});
        end
    endtask

    task automatic monitor();
        beat_t cur;
        beat_t exp;
        cur = {bin, count, cdf, last};
        if (prev_stall) check("stall_hold", 64'({valid, cur}), 64'({1'b1, prev_out}));
        prev_stall = valid && !ready;
        prev_out   = cur;
        if (wr_en) begin
            check("wr_addr", 64'(wr_addr), 64'(wr_next));
            wr_next++;
            wr_cnt++;
        end
        if (valid && ready) begin
            if (q.size() == 0) begin
                check("extra_beat", 64'(q.size()), 64'd1);
            end else begin
                exp = q.pop_front();
                check("beat", 64'(cur), 64'(exp));
                last_cdf = cdf;
                if (last && last_cyc < 0) last_cyc = cyc;
            end
        end
        if (done && done_cyc < 0) done_cyc = cyc;
    endtask

    task automatic sweep(input bit rnd, input bit timing, input bit poke, input int abort_bin);
        push_exp();
        wr_cnt = 0; wr_next = 0; last_cyc = -1; done_cyc = -1; cyc = 0; prev_stall = 1'b0;
        start = 1'b1;
        ready = 1'b1;
        monitor();
        advance();
        start = 1'b0;
        for (int n = 0; n < 3000 && done_cyc < 0; n++) begin
            if (abort_bin >= 0 && valid && bin == AW'(abort_bin)) begin
                rst_n = 1'b0;
                #1;
                check("mid_reset", 64'({valid, bin, count, cdf, last, busy, done, wr_en, rd_addr}), 64'd0);
                q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                advance();
                return;
            end
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (timing && cyc == 1) check("prime_cycle", 64'({busy, valid}), 64'b10);
            if (timing && cyc == 2) check("first_beat", 64'({valid, bin}), 64'({1'b1, 8'h00}));
            monitor();
            // Starts during RUN and in the DONE cycle must both be ignored.
            start = poke && (cyc == 60 || done);
            advance();
        end
        start = 1'b0;
        check("done_seen", 64'(done_cyc >= 0 ? 1 : 0), 64'd1);
        check("busy_low", 64'({busy, valid}), 64'd0);
        check("q_empty", 64'(q.size()), 64'd0);
        check("writes", 64'(wr_cnt), CLR ? 64'd256 : 64'd0);
        if (timing) begin
            check("last_cycle", 64'(last_cyc), 64'd257);
            check("done_cycle", 64'(done_cyc), 64'd258);
        end
        if (CLR) begin
            for (int i = 0; i < NB; i++) img[i] = '0;
        end
        q.delete();
        advance();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = 1'b0; load_ram = 1'b0;
        for (int i = 0; i < NB; i++) img[i] = '0;
        #12;
        check("reset_state", 64'({valid, bin, count, cdf, last, busy, done, wr_en, rd_addr, wr_addr}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        advance();

        // All ones: CDF 1..256 with exact cycle timing.
        for (int i = 0; i < NB; i++) img[i] = 20'd1;
        load_img();
        sweep(1'b0, 1'b1, 1'b0, -1);

        // Full-frame mass in bin 0.
        for (int i = 0; i < NB; i++) img[i] = '0;
        img[0] = 20'd307200;
        load_img();
        sweep(1'b0, 1'b0, 1'b0, -1);
        check("mass_final_cdf", 64'(last_cdf), 64'd307200);

        // Saturation in bin 1 persists to the end.
        for (int i = 0; i < NB; i++) img[i] = CW'($urandom_range(0, 1000));
        img[0] = 20'hFFFFF;
        img[1] = 20'hFFFFF;
        load_img();
        sweep(1'b0, 1'b0, 1'b0, -1);
        check("sat_final_cdf", 64'(last_cdf), 64'hFFFFF);

        // Ramp under random backpressure.
        for (int i = 0; i < NB; i++) img[i] = CW'(i);
        load_img();
        sweep(1'b1, 1'b0, 1'b0, -1);
        check("ramp_final_cdf", 64'(last_cdf), 64'd32640);

        // Second sweep without reloading: zeros when bins were cleared.
        sweep(1'b0, 1'b0, 1'b0, -1);

        // Reset at bin 100, then a fresh sweep with ignored starts.
        for (int i = 0; i < NB; i++) img[i] = CW'(i + 3);
        load_img();
        sweep(1'b0, 1'b0, 1'b0, 100);
        if (CLR) begin
            for (int i = 0; i < 99; i++) img[i] = '0;
        end
        sweep(1'b1, 1'b0, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
